// File: rtl/rv32i_exec_core.sv
// rv32i_exec_core
//   RV32I integer execution slice: combinational decoder, 32x32 register
//   file with registered operand capture, and a registered ALU.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears regfile, operands, alu_out)
//   insn       instruction word, held stable for the whole instruction
//   rden       capture x[rs1]/x[rs2] into rs1_val/rs2_val
//   wren       write rf_wdata into x[rd]
//   rf_wdata   write-back data chosen by the controller
//   opcode     insn[6:2]
//   alu_op     {variant bit, funct3}-style ALU operation
//   invalid    unsupported or illegal encoding
//   rd/rs1/rs2 register fields
//   imm        sign-extended immediate (0 for OP and invalid encodings)
//   rs1_val    registered operand 1
//   rs2_val    registered operand 2
//   alu_out    registered ALU result
module rv32i_exec_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     insn,
    input  logic            rden,
    input  logic            wren,
    input  logic [XLEN-1:0] rf_wdata,
    output logic [4:0]      opcode,
    output logic [3:0]      alu_op,
    output logic            invalid,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] alu_out
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       opc_ok;
    logic       op_bad;
    logic       opimm_bad;

    assign opcode = insn[6:2];
    assign rd     = insn[11:7];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct3 = insn[14:12];
    assign funct7 = insn[31:25];

    always_comb begin
        opc_ok = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
                opc_ok = 1'b1;
            default: opc_ok = 1'b0;
        endcase
    end

    // Only the base and alternate (SUB/SRA) funct7 encodings exist in RV32I.
    assign op_bad = (opcode == OPC_OP) &&
                    (((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                     ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101)));

    // Shift-immediates reuse imm[11:5] as funct7; SLLI has no alternate form.
    assign opimm_bad = (opcode == OPC_OP_IMM) &&
                       ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                       (((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                        ((funct7 == 7'h20) && (funct3 == 3'b001)));

    assign invalid = (insn[1:0] != 2'b11) || !opc_ok || op_bad || opimm_bad;

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OPC_OP)
            alu_op = {insn[30], funct3};
        else if (opcode == OPC_OP_IMM)
            alu_op = {(funct3 == 3'b101) ? insn[30] : 1'b0, funct3};
    end

    always_comb begin
        imm = '0;
        if (!invalid) begin
            case (opcode)
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                    imm = {{20{insn[31]}}, insn[31:20]};
                OPC_STORE:
                    imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
                OPC_BRANCH:
                    imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                OPC_LUI, OPC_AUIPC:
                    imm = {insn[31:12], 12'b0};
                OPC_JAL:
                    imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                default: imm = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file and operand capture. Entry 0 is never written, so it
    // stays at its reset value of zero. Reads see the pre-edge contents,
    // so a same-edge read/write of one register returns the old value.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wren && (rd != 5'd0)) begin
            regs[rd] <= rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_val <= '0;
            rs2_val <= '0;
        end else if (rden) begin
            rs1_val <= regs[rs1];
            rs2_val <= regs[rs2];
        end
    end

    // ------------------------------------------------------------------
    // ALU, result registered every cycle
    // ------------------------------------------------------------------
    logic [XLEN-1:0] in2;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;

    assign in2   = (opcode == OPC_OP_IMM) ? imm : rs2_val;
    assign shamt = in2[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs1_val + in2;
            ALU_SUB:  alu_res = rs1_val - in2;
            ALU_SLL:  alu_res = rs1_val << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(in2))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_val < in2)};
            ALU_XOR:  alu_res = rs1_val ^ in2;
            ALU_SRL:  alu_res = rs1_val >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> shamt);
            ALU_OR:   alu_res = rs1_val | in2;
            ALU_AND:  alu_res = rs1_val & in2;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_out <= '0;
        else      alu_out <= alu_res;
    end

endmodule

// File: tb/tb_rv32i_exec_core.sv
module tb_rv32i_exec_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] insn = 32'h0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] rf_wdata = 32'h0;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [3:0]  alu_op;
    logic        invalid;
    logic [31:0] imm, rs1_val, rs2_val, alu_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_m [32];

    rv32i_exec_core #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .insn(insn), .rden(rden), .wren(wren),
        .rf_wdata(rf_wdata), .opcode(opcode), .alu_op(alu_op), .invalid(invalid),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ISA-level result of an OP / OP-IMM instruction on operand values a, b.
    function automatic logic [31:0] ref_alu(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] s;
        logic [31:0] y;
        logic [4:0]  sh;
        logic        alt;
        s   = i;
        y   = (i[6:0] == 7'h13) ? 32'(s >>> 20) : b;
        sh  = y[4:0];
        alt = i[30];
        case (i[14:12])
            3'd0: ref_alu = (i[6:0] == 7'h33 && alt) ? a - y : a + y;
            3'd1: ref_alu = a << sh;
            3'd2: ref_alu = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: ref_alu = (a < y) ? 32'd1 : 32'd0;
            3'd4: ref_alu = a ^ y;
            3'd5: ref_alu = alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: ref_alu = a | y;
            default: ref_alu = a & y;
        endcase
    endfunction

    // Full controller sequence: capture, compute, write back.
    task automatic exec(input logic [31:0] i, input string nm);
        logic [31:0] e;
        insn = i; rden = 1'b1; wren = 1'b0;
        @(posedge clk); #1 rden = 1'b0;
        chk({nm, " rs1_val"}, rs1_val, rf_m[i[19:15]]);
        @(posedge clk); #1;
        e = ref_alu(i, rf_m[i[19:15]], rf_m[i[24:20]]);
        chk({nm, " alu_out"}, alu_out, e);
        rf_wdata = e; wren = 1'b1;
        @(posedge clk); #1 wren = 1'b0;
        if (i[11:7] != 5'd0) rf_m[i[11:7]] = e;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [4:0] b);
        insn = {7'h0, b, a, 3'b000, 5'd0, 7'h33};
        rden = 1'b1;
        @(posedge clk); #1 rden = 1'b0;
        chk($sformatf("read x%0d", a), rs1_val, rf_m[a]);
        chk($sformatf("read x%0d", b), rs2_val, rf_m[b]);
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        insn = {20'h0, r, 7'h37};
        wren = 1'b1; rf_wdata = v;
        @(posedge clk); #1 wren = 1'b0;
        if (r != 5'd0) rf_m[r] = v;
    endtask

    typedef struct {
        logic [31:0] insn;
        logic [4:0]  op;
        logic [3:0]  aop;
        logic        inv;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } dvec_t;

    dvec_t tbl[$];

    initial begin
        tbl.push_back('{32'h12345337, 5'b01101, 4'b0000, 1'b0, 5'd6,  5'd8,  5'd3,  32'h12345000});
        tbl.push_back('{32'hFFDFF0EF, 5'b11011, 4'b0000, 1'b0, 5'd1,  5'd31, 5'd29, 32'hFFFFFFFC});
        tbl.push_back('{32'h00000000, 5'b00000, 4'b0000, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0});
        tbl.push_back('{32'h022081B3, 5'b01100, 4'b0000, 1'b1, 5'd3,  5'd1,  5'd2,  32'h0});
        tbl.push_back('{32'h402081B3, 5'b01100, 4'b1000, 1'b0, 5'd3,  5'd1,  5'd2,  32'h0});
        tbl.push_back('{32'h40115213, 5'b00100, 4'b1101, 1'b0, 5'd4,  5'd2,  5'd1,  32'h00000401});
        tbl.push_back('{32'h40111213, 5'b00100, 4'b0001, 1'b1, 5'd4,  5'd2,  5'd1,  32'h0});
        tbl.push_back('{32'hFE20AC23, 5'b01000, 4'b0000, 1'b0, 5'd24, 5'd1,  5'd2,  32'hFFFFFFF8});
        tbl.push_back('{32'h00208863, 5'b11000, 4'b0000, 1'b0, 5'd16, 5'd1,  5'd2,  32'h00000010});
        tbl.push_back('{32'hFE000FE3, 5'b11000, 4'b0000, 1'b0, 5'd31, 5'd0,  5'd0,  32'hFFFFFFFE});
        tbl.push_back('{32'hFFFFF297, 5'b00101, 4'b0000, 1'b0, 5'd5,  5'd31, 5'd31, 32'hFFFFF000});
        tbl.push_back('{32'h00000073, 5'b11100, 4'b0000, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0});
        tbl.push_back('{32'h0FF0000F, 5'b00011, 4'b0000, 1'b0, 5'd0,  5'd0,  5'd31, 32'h0});
        tbl.push_back('{32'h00500092, 5'b00100, 4'b0000, 1'b1, 5'd1,  5'd0,  5'd5,  32'h0});
        tbl.push_back('{32'h0000007F, 5'b11111, 4'b0000, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0});
        tbl.push_back('{32'h402091B3, 5'b01100, 4'b1001, 1'b1, 5'd3,  5'd1,  5'd2,  32'h0});
        tbl.push_back('{32'hFFF100E7, 5'b11001, 4'b0000, 1'b0, 5'd1,  5'd2,  5'd31, 32'hFFFFFFFF});
        tbl.push_back('{32'h7FF02383, 5'b00000, 4'b0000, 1'b0, 5'd7,  5'd0,  5'd31, 32'h000007FF});

        for (int r = 0; r < 32; r++) rf_m[r] = 32'h0;

        // Reset held for two cycles; outputs must clear without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("reset alu_out", alu_out, 32'h0);
        chk("reset rs1_val", rs1_val, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int r = 1; r < 32; r += 2) rd_chk(5'(r), 5'(r + 1 < 32 ? r + 1 : r));

        // Decode table
        foreach (tbl[k]) begin
            insn = tbl[k].insn;
            #1;
            chk($sformatf("opcode %h", tbl[k].insn), {27'h0, opcode}, {27'h0, tbl[k].op});
            chk($sformatf("alu_op %h", tbl[k].insn), {28'h0, alu_op}, {28'h0, tbl[k].aop});
            chk($sformatf("invalid %h", tbl[k].insn), {31'h0, invalid}, {31'h0, tbl[k].inv});
            chk($sformatf("fields %h", tbl[k].insn), {17'h0, rd, rs1, rs2},
                {17'h0, tbl[k].rd, tbl[k].rs1, tbl[k].rs2});
            chk($sformatf("imm %h", tbl[k].insn), imm, tbl[k].imm);
        end

        // Directed sequences
        @(negedge clk);
        exec(32'h00500093, "addi x1");
        exec(32'hFFD00113, "addi x2");
        exec(32'h00700013, "addi x0");
        rd_chk(5'd1, 5'd2);
        rd_chk(5'd0, 5'd0);
        chk("x1 value", rf_m[1], 32'd5);
        exec(32'h402081B3, "sub x3");
        chk("sub result model", rf_m[3], 32'd8);
        exec(32'h0020B2B3, "sltu x5");
        exec(32'h0020A2B3, "slt x5");
        insn = 32'h40115213; #1;
        chk("srai alu_op", {28'h0, alu_op}, 32'hD);
        chk("srai shamt", {27'h0, imm[4:0]}, 32'd1);
        exec(32'h40115213, "srai x4");
        exec(32'h00115213, "srli x4");
        rd_chk(5'd3, 5'd4);

        // Same-edge read and write of one register: old value captured.
        insn = 32'h00008093;
        rden = 1'b1; wren = 1'b1; rf_wdata = 32'hDEADBEEF;
        @(posedge clk); #1 rden = 1'b0; wren = 1'b0;
        chk("hazard old value", rs1_val, rf_m[1]);
        rf_m[1] = 32'hDEADBEEF;
        rd_chk(5'd1, 5'd1);

        // Random OP / OP-IMM traffic against the model
        for (int r = 1; r < 8; r++) wr(5'(r), $urandom);
        for (int n = 0; n < 150; n++) begin
            logic [4:0]  ra, rb, rdst;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [11:0] im;
            logic [31:0] ri;
            if (n % 25 == 24) wr(5'($urandom_range(1, 7)), $urandom);
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rdst = 5'($urandom_range(0, 7));
            f3 = 3'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                ri = {f7, rb, ra, f3, rdst, 7'h33};
            end else begin
                im = 12'($urandom);
                if (f3 == 3'd1) im[11:5] = 7'h00;
                if (f3 == 3'd5) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                ri = {im, ra, f3, rdst, 7'h13};
            end
            insn = ri; #1;
            chk($sformatf("rand valid %h", ri), {31'h0, invalid}, 32'h0);
            exec(ri, $sformatf("rand %h", ri));
        end
        for (int r = 1; r < 8; r += 2) rd_chk(5'(r), 5'(r + 1));

        // Reset pulse mid-instruction: everything clears, no write lands.
        exec(32'h00300093, "addi x1 3");
        insn = 32'h402081B3; rden = 1'b1;
        @(posedge clk); #1 rden = 1'b0;
        @(posedge clk); #1;
        wren = 1'b1; rf_wdata = 32'h12345678;
        rst = 1'b0; #1;
        chk("midreset rs1_val", rs1_val, 32'h0);
        chk("midreset rs2_val", rs2_val, 32'h0);
        chk("midreset alu_out", alu_out, 32'h0);
        @(posedge clk);
        @(negedge clk) begin rst = 1'b1; wren = 1'b0; end
        for (int r = 0; r < 32; r++) rf_m[r] = 32'h0;
        rd_chk(5'd1, 5'd2);
        rd_chk(5'd3, 5'd4);
        exec(32'h00500093, "post-reset addi");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
